inv_cipher_arbiter: RTL and testbench

//  - Shares one inverse-cipher core (basla/bitti_o handshake, ~57-cycle latency) between two requesters.
//  - Sequences the core: latches ciphertext, pulses start, waits for done, returns plaintext with requester id.
//  - Sits between the host/DMA decrypt ports and the core. Round-key bus key_i is routed straight to the core, not through this block.

---
 rtl/aes_ctrl_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 13 +
 rtl/inv_cipher_arbiter.sv | 131 +++++++++++++
 tb/tb_inv_cipher_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared FSM encoding and block constants for the inverse-cipher arbiter.
package aes_ctrl_pkg;
    localparam int CORE_LATENCY = 57;
    localparam int BLK_W        = 128;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        ERR   = 3'd4
    } state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin pick; the caller owns last_grant.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic       gnt_idx,
    output logic       gnt_valid
);
    always_comb begin
        gnt_valid = en & |req;
        gnt_idx   = &req ? ~last_grant : req[1];
    end
endmodule

// File: rtl/inv_cipher_arbiter.sv
// inv_cipher_arbiter: shares one inverse-cipher core between two requesters,
// sequencing start/done and returning plaintext tagged with the requester id.
module inv_cipher_arbiter
    import aes_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 80,
    parameter int TO_W    = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [BLK_W-1:0] req_data0_i,
    input  logic [BLK_W-1:0] req_data1_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic             resp_id_o,
    output logic [BLK_W-1:0] resp_data_o,
    output logic             core_basla_o,
    output logic [BLK_W-1:0] core_metin_o,
    input  logic [BLK_W-1:0] core_metin_i,
    input  logic             core_bitti_i,
    output logic             busy_o,
    output logic             err_o
);
    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    logic             basla_q, basla_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_id_q, resp_id_d;
    logic [BLK_W-1:0] metin_q, metin_d;
    logic [BLK_W-1:0] resp_data_q, resp_data_d;
    logic [TO_W-1:0]  count_q, count_d;
    logic             gnt_idx, gnt_valid;

    rr_arbiter2 u_arb (
        .req        (req_valid_i),
        .last_grant (last_grant_q),
        .en         (state_q == IDLE),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid)
    );

    assign req_ready_o  = gnt_valid ? onehot2(gnt_idx) : 2'b00;
    assign resp_valid_o = resp_valid_q;
    assign resp_id_o    = resp_id_q;
    assign resp_data_o  = resp_data_q;
    assign core_basla_o = basla_q;
    assign core_metin_o = metin_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        metin_d      = metin_q;
        basla_d      = 1'b0;
        count_d      = count_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        err_d        = err_q;
        case (state_q)
            IDLE: if (gnt_valid) begin
                state_d      = ISSUE;
                metin_d      = gnt_idx ? req_data1_i : req_data0_i;
                id_d         = gnt_idx;
                last_grant_d = gnt_idx;
                basla_d      = 1'b1;
            end
            ISSUE: begin
                state_d = WAIT;
                count_d = '0;
            end
            WAIT: begin
                count_d = count_q + TO_W'(1);
                if (core_bitti_i) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_id_d    = id_q;
                    resp_data_d  = core_metin_i;
                end else if (count_d == TO_W'(TIMEOUT)) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            RESP: if (resp_ready_i) begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
            end
            default: begin
                state_d      = ERR;
                err_d        = 1'b1;
                resp_valid_d = 1'b0;
            end
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            metin_q      <= '0;
            basla_q      <= 1'b0;
            count_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            metin_q      <= metin_d;
            basla_q      <= basla_d;
            count_q      <= count_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end
endmodule

// File: tb/tb_inv_cipher_arbiter.sv
// tb_inv_cipher_arbiter: directed vectors, an arbitration table and a randomized
// run against a transaction-level model, driving a stub core with fixed latency.
module tb_inv_cipher_arbiter;
    import aes_ctrl_pkg::*;

    localparam int TIMEOUT = 80;
    localparam logic [127:0] CT0 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;

    logic         clk_i = 1'b0, rst_i = 1'b1;
    logic [1:0]   req_valid_i = 2'b00, req_ready_o;
    logic [127:0] req_data0_i = '0, req_data1_i = '0;
    logic         resp_valid_o, resp_ready_i = 1'b0, resp_id_o;
    logic [127:0] resp_data_o, core_metin_o, core_metin_i;
    logic         core_basla_o, core_done, stray = 1'b0, core_dead = 1'b0;
    logic         busy_o, err_o;
    wire          core_bitti_i = core_done | stray;

    inv_cipher_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(7)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_data0_i(req_data0_i), .req_data1_i(req_data1_i), .resp_valid_o(resp_valid_o),
        .resp_ready_i(resp_ready_i), .resp_id_o(resp_id_o), .resp_data_o(resp_data_o),
        .core_basla_o(core_basla_o), .core_metin_o(core_metin_o), .core_metin_i(core_metin_i),
        .core_bitti_i(core_bitti_i), .busy_o(busy_o), .err_o(err_o)
    );

    always #10 clk_i = ~clk_i;

    int n_chk = 0, n_err = 0;

    // Stand-in cipher: the published vector decrypts correctly, anything else gets a fixed scramble.
    function automatic logic [127:0] core_fn(input logic [127:0] c);
        return (c == CT0) ? PT0 : ({c[63:0], c[127:64]} ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    int           core_cnt;
    logic [127:0] core_ct;
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            core_cnt <= 0; core_done <= 1'b0; core_metin_i <= '0; core_ct <= '0;
        end else begin
            core_done <= 1'b0;
            if (core_basla_o) begin
                core_cnt <= CORE_LATENCY - 1; core_ct <= core_metin_o;
            end else if (core_cnt != 0) begin
                core_cnt <= core_cnt - 1;
                if (core_cnt == 1 && !core_dead) begin
                    core_done <= 1'b1; core_metin_i <= core_fn(core_ct);
                end
            end
        end
    end

    int   basla_cnt = 0, basla_dbl = 0;
    logic basla_prev = 1'b0;
    always @(negedge clk_i) begin
        if (core_basla_o && basla_prev) basla_dbl++;
        if (core_basla_o) basla_cnt++;
        basla_prev = core_basla_o;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1; req_valid_i = 2'b00; resp_ready_i = 1'b0; stray = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic wait_accept(output int g);
        int n = 0;
        g = -1;
        while (n < 300) begin
            #1;
            if (|(req_ready_o & req_valid_i)) begin
                g = req_ready_o[1] ? 1 : 0;
                break;
            end
            @(negedge clk_i);
            n++;
        end
        if (g < 0) begin
            n_chk++; n_err++;
            $display("FAIL accept_timeout: got no handshake expected one within 300 cycles");
        end else @(posedge clk_i);
    endtask

    task automatic wait_resp(input int exp_id, input logic [127:0] exp_data, input int hold);
        int n = 0;
        while (!resp_valid_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (!resp_valid_o) begin
            n_chk++; n_err++;
            $display("FAIL resp_timeout: got no resp_valid expected one within 200 cycles");
            return;
        end
        chk("resp_id", 128'(resp_id_o), 128'(exp_id));
        chk("resp_data", resp_data_o, exp_data);
        repeat (hold) begin
            @(negedge clk_i);
            #1;
            chk("hold_valid", 128'(resp_valid_o), 128'd1);
            chk("hold_id", 128'(resp_id_o), 128'(exp_id));
            chk("hold_data", resp_data_o, exp_data);
            chk("hold_ready", 128'(req_ready_o), 128'd0);
        end
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        resp_ready_i = 1'b0;
        req_valid_i  = 2'b00;
        chk("resp_drop", 128'(resp_valid_o), 128'd0);
    endtask

    typedef struct { logic last; logic [1:0] rv; logic [1:0] exp; } arb_vec_t;
    arb_vec_t tbl [8];

    function automatic int rr(input logic [1:0] rv, input int last);
        if (rv == 2'b11) return (last == 1) ? 0 : 1;
        if (rv[0]) return 0;
        if (rv[1]) return 1;
        return -1;
    endfunction

    logic         m_busy, m_rv, m_id;
    int           m_last, m_t;
    logic [127:0] m_data;
    logic [1:0]   exp_rdy;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1);
    end

    initial begin
        int g, left, lat, b0;
        int exp_seq [7];
        logic [127:0] d, d0, d1;
        tbl = '{'{1'b1, 2'b00, 2'b00}, '{1'b1, 2'b01, 2'b01}, '{1'b1, 2'b10, 2'b10}, '{1'b1, 2'b11, 2'b01},
                '{1'b0, 2'b00, 2'b00}, '{1'b0, 2'b01, 2'b01}, '{1'b0, 2'b10, 2'b10}, '{1'b0, 2'b11, 2'b10}};

        do_reset();
        #1;
        chk("rst_busy", 128'(busy_o), 128'd0);
        chk("rst_err", 128'(err_o), 128'd0);
        chk("rst_valid", 128'(resp_valid_o), 128'd0);
        chk("rst_basla", 128'(core_basla_o), 128'd0);
        chk("rst_metin", core_metin_o, 128'd0);
        chk("rst_rdata", resp_data_o, 128'd0);
        chk("rst_ready", 128'(req_ready_o), 128'd0);
        foreach (tbl[i]) if (tbl[i].last) begin
            req_valid_i = tbl[i].rv;
            #1;
            chk("arb_last1", 128'(req_ready_o), 128'(tbl[i].exp));
        end

        // Known-answer block through requester 0
        req_valid_i = 2'b01; req_data0_i = CT0;
        wait_accept(g);
        chk("kat_grant", 128'(g), 128'd0);
        @(negedge clk_i);
        req_valid_i = 2'b00;
        chk("kat_basla", 128'(core_basla_o), 128'd1);
        chk("kat_busy", 128'(busy_o), 128'd1);
        chk("kat_metin", core_metin_o, CT0);
        @(negedge clk_i);
        chk("kat_basla_1cyc", 128'(core_basla_o), 128'd0);
        lat = 1;
        while (!resp_valid_o && lat < 200) begin
            @(negedge clk_i);
            lat++;
        end
        chk("kat_latency", 128'(lat), 128'd58);
        wait_resp(0, PT0, 0);
        foreach (tbl[i]) if (!tbl[i].last) begin
            req_valid_i = tbl[i].rv;
            #1;
            chk("arb_last0", 128'(req_ready_o), 128'(tbl[i].exp));
        end
        req_valid_i = 2'b00;
        stray = 1'b1;
        @(negedge clk_i);
        stray = 1'b0;
        @(negedge clk_i);
        chk("stray_busy", 128'(busy_o), 128'd0);
        chk("stray_valid", 128'(resp_valid_o), 128'd0);
        chk("stray_rdata", resp_data_o, PT0);

        // Both requesters valid right after reset
        do_reset();
        b0 = basla_cnt;
        d0 = rnd128(); d1 = rnd128();
        req_data0_i = d0; req_data1_i = d1; req_valid_i = 2'b11;
        wait_accept(g);
        chk("both_first", 128'(g), 128'd0);
        @(negedge clk_i);
        req_valid_i = 2'b10;
        wait_resp(0, core_fn(d0), 0);
        req_valid_i = 2'b10;
        wait_accept(g);
        chk("both_second", 128'(g), 128'd1);
        @(negedge clk_i);
        req_valid_i = 2'b00;
        wait_resp(1, core_fn(d1), 0);
        chk("both_basla_count", 128'(basla_cnt - b0), 128'd2);

        // Requester 1 always valid, requester 0 issues three blocks
        do_reset();
        exp_seq = '{0, 1, 0, 1, 0, 1, 1};
        left = 3;
        req_data0_i = rnd128(); req_data1_i = rnd128();
        for (int i = 0; i < 7; i++) begin
            req_valid_i = {1'b1, left > 0};
            wait_accept(g);
            chk("rr_seq", 128'(g), 128'(exp_seq[i]));
            d = (g == 1) ? req_data1_i : req_data0_i;
            @(negedge clk_i);
            if (g == 0) begin
                left--;
                req_data0_i = rnd128();
            end else req_data1_i = rnd128();
            req_valid_i = {1'b1, left > 0};
            wait_resp(g, core_fn(d), 0);
        end

        // Consumer stalls for 20 cycles while both requesters wait
        d = rnd128();
        req_data0_i = d; req_valid_i = 2'b01;
        wait_accept(g);
        chk("stall_grant", 128'(g), 128'd0);
        @(negedge clk_i);
        req_valid_i = 2'b11;
        wait_resp(0, core_fn(d), 20);

        // Dead core: sticky timeout
        core_dead = 1'b1;
        req_valid_i = 2'b01;
        wait_accept(g);
        chk("to_grant", 128'(g), 128'd0);
        @(negedge clk_i);
        req_valid_i = 2'b11;
        repeat (TIMEOUT) @(negedge clk_i);
        chk("to_err_early", 128'(err_o), 128'd0);
        @(negedge clk_i);
        #1;
        chk("to_err", 128'(err_o), 128'd1);
        chk("to_busy", 128'(busy_o), 128'd1);
        chk("to_ready", 128'(req_ready_o), 128'd0);
        chk("to_valid", 128'(resp_valid_o), 128'd0);
        repeat (10) @(negedge clk_i);
        #1;
        chk("to_sticky", 128'(err_o), 128'd1);
        chk("to_ready_late", 128'(req_ready_o), 128'd0);
        core_dead = 1'b0;
        do_reset();
        chk("to_cleared", 128'(err_o), 128'd0);

        // Reset 30 cycles into WAIT, then a fresh request
        req_data1_i = rnd128() | 128'd1; req_valid_i = 2'b10;
        wait_accept(g);
        chk("mid_grant", 128'(g), 128'd1);
        @(negedge clk_i);
        req_valid_i = 2'b00;
        repeat (30) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("mid_busy", 128'(busy_o), 128'd0);
        chk("mid_metin", core_metin_o, 128'd0);
        chk("mid_basla", 128'(core_basla_o), 128'd0);
        chk("mid_valid", 128'(resp_valid_o), 128'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        d = rnd128();
        req_data0_i = d; req_valid_i = 2'b01;
        wait_accept(g);
        chk("mid_fresh_grant", 128'(g), 128'd0);
        @(negedge clk_i);
        req_valid_i = 2'b00;
        wait_resp(0, core_fn(d), 0);

        // Randomized traffic against a transaction-level model
        do_reset();
        m_busy = 1'b0; m_rv = 1'b0; m_id = 1'b0; m_last = 1; m_t = 0; m_data = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            chk("rnd_valid", 128'(resp_valid_o), 128'(m_rv));
            chk("rnd_busy", 128'(busy_o), 128'(m_busy));
            if (m_rv) begin
                chk("rnd_id", 128'(resp_id_o), 128'(m_id));
                chk("rnd_data", resp_data_o, core_fn(m_data));
            end
            req_valid_i  = 2'($urandom_range(0, 3));
            req_data0_i  = rnd128();
            req_data1_i  = rnd128();
            resp_ready_i = 1'($urandom_range(0, 1));
            #1;
            g = rr(req_valid_i, m_last);
            exp_rdy = (!m_busy && g >= 0) ? 2'(2'b01 << g) : 2'b00;
            chk("rnd_ready", 128'(req_ready_o), 128'(exp_rdy));
            @(posedge clk_i);
            if (exp_rdy != 2'b00) begin
                m_busy = 1'b1; m_t = 0; m_id = 1'(g); m_last = g;
                m_data = (g == 1) ? req_data1_i : req_data0_i;
            end else if (m_busy) begin
                if (m_rv && resp_ready_i) begin
                    m_busy = 1'b0; m_rv = 1'b0;
                end else begin
                    m_t++;
                    m_rv = (m_t >= 58);
                end
            end
        end
        @(negedge clk_i);
        req_valid_i = 2'b00; resp_ready_i = 1'b0;
        chk("basla_single_cycle", 128'(basla_dbl), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
